// File: rtl/m31_dot_product_lanes_if.sv
// Handshake and operand bus for the multi-lane M31 dot-product engine.
interface m31_dot_product_lanes_if #(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16
);

  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec1;
  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec2;
  logic                                   start;
  logic                                   accumulate;
  logic                                   ready;
  logic [WORD_WIDTH-1:0]                  result;
  logic                                   valid;
  logic                                   result_ack;

  modport master (
    output vec1, vec2, start, accumulate, result_ack,
    input  ready, result, valid
  );

  modport slave (
    input  vec1, vec2, start, accumulate, result_ack,
    output ready, result, valid
  );

endinterface

// File: rtl/m31_dot_product_lanes.sv
// Multi-lane M31 (p = 2^31-1) dot product with pipelined lane multipliers,
// optional accumulation onto the previous result, and a start/valid/ack handshake.
module m31_dot_product_lanes #(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned MUL_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  m31_dot_product_lanes_if.slave  bus
);

  localparam int unsigned W        = 31;
  localparam int unsigned PROD_W   = 2 * W;
  localparam int unsigned GROUPS   = (VECTOR_SIZE + LANES - 1) / LANES;
  localparam int unsigned PAD_SIZE = GROUPS * LANES;
  localparam int unsigned PAD_W    = PAD_SIZE * W;
  localparam int unsigned SHIFT    = LANES * W;
  localparam int unsigned SUM_W    = W + $clog2(LANES + 1);
  localparam int unsigned CNT_MAX  = (GROUPS > MUL_STAGES + 1) ? GROUPS : MUL_STAGES + 1;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [31:0] P32 = 32'h7FFF_FFFF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Elaboration-time parameter legality
  if (WORD_WIDTH != 31) begin : g_bad_word_width
    $error("m31_dot_product_lanes: WORD_WIDTH must be 31");
  end
  if (VECTOR_SIZE < 1) begin : g_bad_vector_size
    $error("m31_dot_product_lanes: VECTOR_SIZE must be >= 1");
  end
  if (LANES < 1 || LANES > VECTOR_SIZE) begin : g_bad_lanes
    $error("m31_dot_product_lanes: LANES must be in [1, VECTOR_SIZE]");
  end
  if (MUL_STAGES < 1) begin : g_bad_mul_stages
    $error("m31_dot_product_lanes: MUL_STAGES must be >= 1");
  end

  // Reduce a 62-bit product into [0, p-1]: lo31 + hi31, one conditional subtract
  function automatic logic [W-1:0] fold_prod(input logic [PROD_W-1:0] x);
    logic [31:0] s;
    s = 32'(x[W-1:0]) + 32'(x[PROD_W-1:W]);
    if (s >= P32) s = s - P32;
    return s[W-1:0];
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] grp_q, grp_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             accept_c;
  logic             issue_c;
  logic             finish_c;

  logic [PAD_W-1:0]  va_q, vb_q;
  logic [PAD_W-1:0]  va_load_c, vb_load_c;
  logic [PROD_W-1:0] prod_q [MUL_STAGES][LANES];
  logic [MUL_STAGES-1:0] pv_q;
  logic [W-1:0]      lane_res_c [LANES];
  logic [SUM_W-1:0]  sum_c;
  logic [31:0]       fold_c;
  logic [W-1:0]      acc_q;
  logic [W-1:0]      seed_c;
  logic [W-1:0]      result_q;

  assign bus.ready  = ready_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

  // State and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      drain_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      drain_q <= drain_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, counters and control strobes
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    drain_d  = drain_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    accept_c = 1'b0;
    issue_c  = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = S_RUN;
          grp_d    = '0;
          ready_d  = 1'b0;
        end
      end
      S_RUN: begin
        issue_c = 1'b1;
        if (grp_q == CNT_W'(GROUPS - 1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          grp_d = grp_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // MUL_STAGES cycles for the last products plus one for the final accumulate
        if (drain_q == CNT_W'(MUL_STAGES)) begin
          finish_c = 1'b1;
          state_d  = S_DONE;
          valid_d  = 1'b1;
          ready_d  = 1'b1;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // start doubles as an implicit acknowledge and takes priority
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = S_RUN;
          grp_d    = '0;
          ready_d  = 1'b0;
          valid_d  = 1'b0;
        end else if (bus.result_ack) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // Zero-padded operand images so the final group's spare lanes multiply by 0
  always_comb begin
    va_load_c = '0;
    vb_load_c = '0;
    va_load_c[VECTOR_SIZE*W-1:0] = bus.vec1;
    vb_load_c[VECTOR_SIZE*W-1:0] = bus.vec2;
  end

  // Operand capture on accept, then shift one group per RUN cycle into the low lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      va_q <= '0;
      vb_q <= '0;
    end else if (accept_c) begin
      va_q <= va_load_c;
      vb_q <= vb_load_c;
    end else if (issue_c) begin
      va_q <= va_q >> SHIFT;
      vb_q <= vb_q >> SHIFT;
    end
  end

  // Lane multiplier pipeline; the valid chain is cleared on reset so nothing stale lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_q <= '0;
      for (int s = 0; s < int'(MUL_STAGES); s++) begin
        for (int l = 0; l < int'(LANES); l++) begin
          prod_q[s][l] <= '0;
        end
      end
    end else begin
      pv_q[0] <= issue_c;
      for (int l = 0; l < int'(LANES); l++) begin
        prod_q[0][l] <= PROD_W'(va_q[l*W +: W]) * PROD_W'(vb_q[l*W +: W]);
      end
      for (int s = 1; s < int'(MUL_STAGES); s++) begin
        pv_q[s] <= pv_q[s-1];
        for (int l = 0; l < int'(LANES); l++) begin
          prod_q[s][l] <= prod_q[s-1][l];
        end
      end
    end
  end

  // Per-lane residues of the pipeline output
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      lane_res_c[l] = fold_prod(prod_q[MUL_STAGES-1][l]);
    end
  end

  // Lane residues plus accumulator, folded back into [0, p-1]
  always_comb begin
    sum_c = SUM_W'(acc_q);
    for (int l = 0; l < int'(LANES); l++) begin
      sum_c = sum_c + SUM_W'(lane_res_c[l]);
    end
    fold_c = 32'(sum_c[W-1:0]) + 32'(sum_c[SUM_W-1:W]);
    if (fold_c >= P32) fold_c = fold_c - P32;
  end

  assign seed_c = bus.accumulate ? result_q : '0;

  // Accumulator: seeded on accept, updated as each group's products emerge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (accept_c) begin
      acc_q <= seed_c;
    end else if (pv_q[MUL_STAGES-1]) begin
      acc_q <= fold_c[W-1:0];
    end
  end

  // Result register, also the seed source for the next accumulate run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else if (finish_c) begin
      result_q <= acc_q;
    end
  end

endmodule

// File: tb/tb_m31_dot_product_lanes.sv
// Scoreboard bench for m31_dot_product_lanes: a 16/4/2 instance and a padded 10/4/2 instance.
module tb_m31_dot_product_lanes;

  typedef logic [15:0][30:0] vec_t;

  localparam int LAT0 = 7;
  localparam int LAT1 = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned exp_res0[$];
  longint      exp_cyc0[$];
  int unsigned exp_res1[$];
  longint      exp_cyc1[$];

  m31_dot_product_lanes_if #(.WORD_WIDTH(31), .VECTOR_SIZE(16)) bus0 ();
  m31_dot_product_lanes_if #(.WORD_WIDTH(31), .VECTOR_SIZE(10)) bus1 ();

  m31_dot_product_lanes #(.WORD_WIDTH(31), .VECTOR_SIZE(16), .LANES(4), .MUL_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  m31_dot_product_lanes #(.WORD_WIDTH(31), .VECTOR_SIZE(10), .LANES(4), .MUL_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t fill(input logic [30:0] x);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = x;
    return v;
  endfunction

  function automatic vec_t ramp();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 31'(i + 1);
    return v;
  endfunction

  // Monitors: on each rising valid, pop and compare result and latency
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;
  always @(negedge clk) begin
    if (bus0.valid && !pv0) begin
      if (exp_res0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0_unexpected_valid: got result %0d with empty scoreboard", bus0.result);
      end else begin
        check("dut0_result", longint'(bus0.result), longint'(exp_res0.pop_front()));
        check("dut0_latency_cycle", cyc, exp_cyc0.pop_front());
      end
    end
    pv0 = bus0.valid;
  end

  always @(negedge clk) begin
    if (bus1.valid && !pv1) begin
      if (exp_res1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_valid: got result %0d with empty scoreboard", bus1.result);
      end else begin
        check("dut1_result", longint'(bus1.result), longint'(exp_res1.pop_front()));
        check("dut1_latency_cycle", cyc, exp_cyc1.pop_front());
      end
    end
    pv1 = bus1.valid;
  end

  // Issue one start on dut0, then scramble the operand inputs to prove they were captured
  task automatic issue0(input vec_t v1, input vec_t v2, input logic acc, input int unsigned exp);
    @(negedge clk);
    check("dut0_ready_before_start", longint'(bus0.ready), 1);
    bus0.vec1 = v1;
    bus0.vec2 = v2;
    bus0.accumulate = acc;
    bus0.start = 1'b1;
    exp_res0.push_back(exp);
    exp_cyc0.push_back(cyc + 1 + LAT0);
    @(negedge clk);
    bus0.start = 1'b0;
    bus0.vec1 = ~v1;
    bus0.vec2 = ~v2;
    bus0.accumulate = ~acc;
    check("dut0_valid_low_after_accept", longint'(bus0.valid), 0);
    check("dut0_ready_low_after_accept", longint'(bus0.ready), 0);
  endtask

  task automatic issue1(input vec_t v1, input vec_t v2, input logic acc, input int unsigned exp);
    @(negedge clk);
    check("dut1_ready_before_start", longint'(bus1.ready), 1);
    bus1.vec1 = v1[9:0];
    bus1.vec2 = v2[9:0];
    bus1.accumulate = acc;
    bus1.start = 1'b1;
    exp_res1.push_back(exp);
    exp_cyc1.push_back(cyc + 1 + LAT1);
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.vec1 = ~v1[9:0];
    bus1.vec2 = ~v2[9:0];
    check("dut1_valid_low_after_accept", longint'(bus1.valid), 0);
  endtask

  task automatic wait_valid0(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus0.valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut0_valid_timeout: no valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_valid1(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus1.valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut1_valid_timeout: no valid within %0d cycles", budget);
    end
  endtask

  task automatic ack0();
    @(negedge clk);
    bus0.result_ack = 1'b1;
    @(negedge clk);
    bus0.result_ack = 1'b0;
    check("dut0_valid_low_after_ack", longint'(bus0.valid), 0);
    check("dut0_ready_high_after_ack", longint'(bus0.ready), 1);
  endtask

  task automatic ack1();
    @(negedge clk);
    bus1.result_ack = 1'b1;
    @(negedge clk);
    bus1.result_ack = 1'b0;
    check("dut1_valid_low_after_ack", longint'(bus1.valid), 0);
  endtask

  initial begin
    bus0.vec1 = '0; bus0.vec2 = '0; bus0.start = 1'b0; bus0.accumulate = 1'b0; bus0.result_ack = 1'b0;
    bus1.vec1 = '0; bus1.vec2 = '0; bus1.start = 1'b0; bus1.accumulate = 1'b0; bus1.result_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ready", longint'(bus0.ready), 1);
    check("reset_valid", longint'(bus0.valid), 0);
    check("reset_result", longint'(bus0.result), 0);
    check("reset_ready_dut1", longint'(bus1.ready), 1);
    reset = 1'b1;

    // Ramp 1..16 against ones: 136, latency 7
    issue0(ramp(), fill(31'd1), 1'b0, 136);
    wait_valid0(20);
    check("ready_with_valid", longint'(bus0.ready), 1);
    ack0();

    // Modular wrap cases
    issue0(fill(31'h7FFF_FFFE), fill(31'h7FFF_FFFE), 1'b0, 16);
    wait_valid0(20);
    ack0();
    issue0(fill(31'h4000_0000), fill(31'd2), 1'b0, 16);
    wait_valid0(20);
    ack0();
    issue0(fill(31'h7FFF_FFFF), fill(31'd5), 1'b0, 0);
    wait_valid0(20);
    ack0();

    // Accumulate chaining; the later starts land in DONE without result_ack
    issue0(ramp(), fill(31'd1), 1'b0, 136);
    wait_valid0(20);
    issue0(ramp(), fill(31'd1), 1'b1, 272);
    wait_valid0(20);
    issue0(ramp(), fill(31'd1), 1'b0, 136);
    wait_valid0(20);
    ack0();
    issue0(ramp(), fill(31'd1), 1'b1, 272);
    wait_valid0(20);
    ack0();

    // Padding: 10 elements over 4 lanes, latency 6
    issue1(fill(31'd1), fill(31'd1), 1'b0, 10);
    wait_valid1(20);
    ack1();

    // Handshake: start in RUN ignored, result held while unacknowledged
    issue0(ramp(), fill(31'd1), 1'b0, 136);
    @(negedge clk);
    check("ready_low_in_run", longint'(bus0.ready), 0);
    bus0.vec1 = fill(31'd7);
    bus0.vec2 = fill(31'd7);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_valid0(20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", longint'(bus0.valid), 1);
      check("hold_result", longint'(bus0.result), 136);
    end
    ack0();

    // Asynchronous reset two cycles into RUN
    issue0(ramp(), fill(31'd1), 1'b0, 136);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_valid", longint'(bus0.valid), 0);
    check("async_reset_ready", longint'(bus0.ready), 1);
    check("async_reset_result", longint'(bus0.result), 0);
    exp_res0.delete();
    exp_cyc0.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stale_valid_after_reset", longint'(bus0.valid), 0);

    issue0(ramp(), fill(31'd1), 1'b1, 136);
    wait_valid0(20);
    issue0(ramp(), fill(31'd1), 1'b0, 136);
    wait_valid0(20);
    issue0(ramp(), fill(31'd1), 1'b1, 272);
    wait_valid0(20);
    ack0();

    repeat (3) @(negedge clk);
    check("dut0_scoreboard_empty", longint'(exp_res0.size()), 0);
    check("dut1_scoreboard_empty", longint'(exp_res1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
